// File: rtl/alu_mc.sv
// alu_mc: execute-stage ALU with single-cycle logic/arith ops
// and a multi-cycle restoring unsigned divider for MOD/quotient.
module alu_mc #(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       ALUOp,
  input  logic             Start,
  output logic [WIDTH-1:0] Result,
  output logic [WIDTH-1:0] Quotient,
  output logic             C,
  output logic             V,
  output logic             Zero,
  output logic             We,
  output logic             Busy
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_XOR = 3'b010;
  localparam logic [2:0] OP_NOR = 3'b011;
  localparam logic [2:0] OP_SLT = 3'b100;
  localparam logic [2:0] OP_ADD = 3'b101;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_MOD = 3'b111;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   p;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] dvsr;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic             busy_q;

  // SLT shares the subtractor with SUB
  logic             is_sub;
  logic [WIDTH-1:0] bin;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  assign is_sub = (ALUOp == OP_SUB) || (ALUOp == OP_SLT);
  assign bin    = is_sub ? ~B : B;
  assign {cout, sum} = {1'b0, A} + {1'b0, bin}
                     + {{WIDTH{1'b0}}, is_sub};
  assign ovf = (A[WIDTH-1] == bin[WIDTH-1])
            && (sum[WIDTH-1] != A[WIDTH-1]);

  logic [WIDTH-1:0] res;
  logic             c_o;
  logic             v_o;

  always_comb begin
    res = '0;
    c_o = 1'b0;
    v_o = 1'b0;
    unique case (ALUOp)
      OP_AND: res = A & B;
      OP_OR:  res = A | B;
      OP_XOR: res = A ^ B;
      OP_NOR: res = ~(A | B);
      OP_SLT: res = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ ovf};
      OP_ADD, OP_SUB: begin
        res = sum;
        c_o = cout;
        v_o = ovf;
      end
      OP_MOD: res = rem;
      default: res = '0;
    endcase
  end

  assign Result   = res;
  assign C        = c_o;
  assign V        = v_o;
  assign Zero     = (res == '0);
  assign Quotient = quo;
  assign Busy     = busy_q;

  always_comb begin
    We = 1'b1;
    if (state == BUSY)
      We = 1'b0;
    else if (ALUOp == OP_MOD)
      We = (state == DONE);
  end

  // One restoring step: shift in next dividend bit, trial subtract
  logic [WIDTH:0]   p_sh;
  logic             ge;
  logic [WIDTH:0]   p_nx;
  logic [WIDTH-1:0] q_nx;

  assign p_sh = {p[WIDTH-1:0], q[WIDTH-1]};
  assign ge   = (p_sh >= {1'b0, dvsr});
  assign p_nx = ge ? (p_sh - {1'b0, dvsr}) : p_sh;
  assign q_nx = {q[WIDTH-2:0], ge};

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state  <= IDLE;
      cnt    <= '0;
      p      <= '0;
      q      <= '0;
      dvsr   <= '0;
      rem    <= '0;
      quo    <= '0;
      busy_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (Start && (ALUOp == OP_MOD)) begin
            q    <= A;
            dvsr <= B;
            p    <= '0;
            cnt  <= CW'(WIDTH);
            if (B == '0) begin
              rem   <= A;
              quo   <= '1;
              state <= DONE;
            end else begin
              state  <= BUSY;
              busy_q <= 1'b1;
            end
          end
        end
        BUSY: begin
          p   <= p_nx;
          q   <= q_nx;
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            rem    <= p_nx[WIDTH-1:0];
            quo    <= q_nx;
            state  <= DONE;
            busy_q <= 1'b0;
          end
        end
        DONE: state <= IDLE;
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

endmodule
